// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared front-end FSM encodings and register-file constants
package pipe_hazard_ctrl_pkg;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;
  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MDU_WAIT  = 2'd1,
    ST_IMEM_WAIT = 2'd2
  } state_e;
endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// pipe_hazard_ctrl_hazard_detect: load-use compare between ID sources and the load in EX
module pipe_hazard_ctrl_hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rs_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_mem_read_i,
  input  logic [REG_W-1:0] ex_rd_i,
  output logic             load_use_o
);
  assign load_use_o = ex_mem_read_i && ex_rd_i != REG_ZERO &&
                      ((id_uses_rs_i && id_rs_i == ex_rd_i) || (id_uses_rt_i && id_rt_i == ex_rd_i));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: front-end sequencer for load-use, branch, MUL/DIV and IMEM wait hazards
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MDU_LAT      = 4,
  parameter int IMEM_TIMEOUT = 64,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_branch_taken,
  input  logic             ex_mdu_start,
  input  logic             imem_ready,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_stall,
  output logic             imem_err,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam int MDU_W  = $clog2(MDU_LAT + 1);
  localparam int WAIT_W = $clog2(IMEM_TIMEOUT + 1);
  state_e state_q, state_d;
  logic [MDU_W-1:0] mdu_cnt_q, mdu_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic imem_err_q;
  logic [CNT_W-1:0] stall_cycles_q;
  logic load_use;
  logic pc_we_c, if_id_we_c, flush_c, bubble_c, ex_stall_c;

  pipe_hazard_ctrl_hazard_detect u_hazard_detect (
    .id_rs_i      (id_rs),
    .id_rt_i      (id_rt),
    .id_uses_rs_i (id_uses_rs),
    .id_uses_rt_i (id_uses_rt),
    .ex_mem_read_i(ex_mem_read),
    .ex_rd_i      (ex_rd),
    .load_use_o   (load_use)
  );

  always_comb begin
    state_d    = ST_RUN;
    mdu_cnt_d  = mdu_cnt_q;
    wait_cnt_d = wait_cnt_q;
    pc_we_c    = 1'b1;
    if_id_we_c = 1'b1;
    flush_c    = 1'b0;
    bubble_c   = 1'b0;
    ex_stall_c = 1'b0;
    case (state_q)
      ST_MDU_WAIT: begin
        pc_we_c    = 1'b0;
        if_id_we_c = 1'b0;
        ex_stall_c = 1'b1;
        mdu_cnt_d  = mdu_cnt_q - 1'b1;
        state_d    = mdu_cnt_q == MDU_W'(1) ? ST_RUN : ST_MDU_WAIT;
      end
      ST_IMEM_WAIT: begin
        pc_we_c    = 1'b0;
        state_d    = ST_IMEM_WAIT;
        wait_cnt_d = wait_cnt_q == WAIT_W'(IMEM_TIMEOUT) ? wait_cnt_q : wait_cnt_q + 1'b1;
        if (ex_branch_taken) begin
          pc_we_c    = 1'b1;
          flush_c    = 1'b1;
          bubble_c   = 1'b1;
          wait_cnt_d = '0;
          state_d    = ST_RUN;
        end else if (load_use) begin
          if_id_we_c = 1'b0;
          bubble_c   = 1'b1;
        end else if (imem_ready) begin
          pc_we_c    = 1'b1;
          wait_cnt_d = '0;
          state_d    = ST_RUN;
        end else begin
          flush_c = 1'b1;
        end
      end
      default: begin
        if (ex_branch_taken) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
        end else if (ex_mdu_start) begin
          pc_we_c    = 1'b0;
          if_id_we_c = 1'b0;
          ex_stall_c = 1'b1;
          mdu_cnt_d  = MDU_W'(MDU_LAT - 1);
          state_d    = ST_MDU_WAIT;
        end else if (load_use) begin
          pc_we_c    = 1'b0;
          if_id_we_c = 1'b0;
          bubble_c   = 1'b1;
        end else if (!imem_ready) begin
          pc_we_c    = 1'b0;
          flush_c    = 1'b1;
          wait_cnt_d = WAIT_W'(1);
          state_d    = ST_IMEM_WAIT;
        end
      end
    endcase
  end

  // While reset is asserted the latches see NOPs and the PC holds, regardless of state
  assign pc_we        = reset_n & pc_we_c;
  assign if_id_we     = reset_n & if_id_we_c;
  assign if_id_flush  = ~reset_n | flush_c;
  assign id_ex_bubble = ~reset_n | bubble_c;
  assign ex_stall     = reset_n & ex_stall_c;
  assign imem_err     = imem_err_q;
  assign stall_cycles = stall_cycles_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_RUN;
      mdu_cnt_q      <= '0;
      wait_cnt_q     <= '0;
      imem_err_q     <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      mdu_cnt_q      <= mdu_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      imem_err_q     <= imem_err_q | (wait_cnt_d == WAIT_W'(IMEM_TIMEOUT));
      stall_cycles_q <= (!pc_we && !(&stall_cycles_q)) ? stall_cycles_q + 1'b1 : stall_cycles_q;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed hazard sequences with hand-computed control vectors
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic id_uses_rs = 1'b0, id_uses_rt = 1'b0, ex_mem_read = 1'b0;
  logic ex_branch_taken = 1'b0, ex_mdu_start = 1'b0, imem_ready = 1'b1;
  logic pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_stall, imem_err;
  logic s_pc_we, s_if_id_we, s_if_id_flush, s_id_ex_bubble, s_ex_stall, s_imem_err;
  logic [31:0] stall_cycles;
  logic [3:0] s_stall_cycles;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .ex_mdu_start(ex_mdu_start),
    .imem_ready(imem_ready), .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .ex_stall(ex_stall), .imem_err(imem_err),
    .stall_cycles(stall_cycles)
  );

  pipe_hazard_ctrl #(.CNT_W(4)) dut_small (
    .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .ex_mdu_start(ex_mdu_start),
    .imem_ready(imem_ready), .pc_we(s_pc_we), .if_id_we(s_if_id_we), .if_id_flush(s_if_id_flush),
    .id_ex_bubble(s_id_ex_bubble), .ex_stall(s_ex_stall), .imem_err(s_imem_err),
    .stall_cycles(s_stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // vector order: {pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_stall}
  task automatic chk_ctl(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_stall}, {27'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; ex_rd = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; ex_mdu_start = 1'b0; imem_ready = 1'b1;
  endtask

  initial begin
    #2;
    chk_ctl("reset_outputs", 5'b00110);
    chk("reset_err", {31'd0, imem_err}, 32'd0);
    chk("reset_stall_cnt", stall_cycles, 32'd0);
    #10 reset_n = 1'b1;
    tick();
    chk_ctl("run_idle", 5'b11000);

    ex_mem_read = 1'b1; ex_rd = 5'd2; id_rs = 5'd2; id_uses_rs = 1'b1; #1;
    chk_ctl("load_use_rs", 5'b00010);
    tick();
    ex_rd = 5'd0; id_rs = 5'd0; #1;
    chk_ctl("load_use_r0", 5'b11000);
    idle(); ex_mem_read = 1'b1; ex_rd = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b1; #1;
    chk_ctl("load_use_rt", 5'b00010);
    tick();
    id_uses_rt = 1'b0; #1;
    chk_ctl("rt_not_used", 5'b11000);
    chk("stall_after_lu", stall_cycles, 32'd2);

    idle(); ex_mdu_start = 1'b1; #1;
    chk_ctl("mdu_start", 5'b00001);
    tick();
    ex_mdu_start = 1'b0; ex_branch_taken = 1'b1; #1;
    chk_ctl("mdu_wait1_branch_ignored", 5'b00001);
    tick();
    ex_branch_taken = 1'b0; #1;
    chk_ctl("mdu_wait2", 5'b00001);
    tick();
    chk_ctl("mdu_wait3", 5'b00001);
    tick();
    chk_ctl("mdu_done", 5'b11000);

    ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs = 5'd7; id_uses_rs = 1'b1; #1;
    chk_ctl("branch_over_load_use", 5'b11110);
    tick();
    idle(); #1;
    chk_ctl("after_branch", 5'b11000);

    imem_ready = 1'b0; #1;
    chk_ctl("imem_miss1", 5'b01100);
    tick();
    chk_ctl("imem_miss2", 5'b01100);
    tick();
    chk_ctl("imem_miss3", 5'b01100);
    tick();
    imem_ready = 1'b1; #1;
    chk_ctl("imem_resume", 5'b11000);
    tick();
    chk_ctl("imem_run", 5'b11000);
    chk("stall_after_imem", stall_cycles, 32'd9);

    imem_ready = 1'b0; tick();
    ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs = 5'd3; id_uses_rs = 1'b1; #1;
    chk_ctl("imem_wait_load_use", 5'b00010);
    tick();
    idle(); imem_ready = 1'b0; ex_branch_taken = 1'b1; #1;
    chk_ctl("imem_wait_branch", 5'b11110);
    tick();
    idle(); #1;
    chk_ctl("branch_back_to_run", 5'b11000);
    chk("stall_mid", stall_cycles, 32'd11);
    chk("stall_small_mid", {28'd0, s_stall_cycles}, 32'd11);
    chk("err_still_clear", {31'd0, imem_err}, 32'd0);

    imem_ready = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (i == 63) chk("err_before_timeout", {31'd0, imem_err}, 32'd0);
    end
    chk("err_at_timeout", {31'd0, imem_err}, 32'd1);
    imem_ready = 1'b1; #1;
    chk_ctl("resume_after_timeout", 5'b11000);
    chk("stall_big", stall_cycles, 32'd75);
    chk("stall_small_sat", {28'd0, s_stall_cycles}, 32'd15);
    tick();
    chk("err_sticky", {31'd0, imem_err}, 32'd1);
    chk("stall_small_hold", {28'd0, s_stall_cycles}, 32'd15);

    ex_mdu_start = 1'b1; #1;
    chk_ctl("mdu_before_reset", 5'b00001);
    tick();
    ex_mdu_start = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk_ctl("async_reset_outputs", 5'b00110);
    chk("async_reset_err", {31'd0, imem_err}, 32'd0);
    chk("async_reset_cnt", stall_cycles, 32'd0);
    #2 reset_n = 1'b1;
    #1;
    chk_ctl("post_reset_run", 5'b11000);
    tick();
    chk_ctl("post_reset_edge", 5'b11000);
    chk("post_reset_small_cnt", {28'd0, s_stall_cycles}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
